rx_event_scheduler: RTL and testbench
=====================================

# rx_event_scheduler

Round-robin scheduler that collects per-frame RX MAC Lite outcome events (passed/discarded) from all ETH channels of one network module and serialises them into a single MVB record stream toward the statistics/user side. Each channel gets saturating pending counters, so the unstoppable per-channel event inputs never need backpressure. Only the shared output port is arbitrated. The block sits in the network module logic next to the per-channel RX MAC Lite instances, on the user clock domain.

## Interface
- ETH_CHANNELS, 4: number of channels; 1..16.
- REGIONS, 1: event slots per channel per cycle (MFB regions of RX MAC Lite).
- CNT_W, 16: width of each pending counter and output count field; >= 2.
- CLK  in  1  clock; all logic rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- RX_EV_VLD  in  ETH_CHANNELS*REGIONS  event valid; bit ch*REGIONS+r is channel ch, region r.
- RX_EV_DISC  in  ETH_CHANNELS*REGIONS  1 = frame discarded, 0 = passed; meaningful only with its VLD bit.
- TX_CHAN  out  max(1,clog2(ETH_CHANNELS))  channel ID of the record.
- TX_DISC_CNT  out  CNT_W  discarded frames in the record.
- TX_PASS_CNT  out  CNT_W  passed frames in the record.
- TX_OVF  out  1  at least one counter of this record saturated.
- TX_SRC_RDY  out  1  record valid.
- TX_DST_RDY  in  1  consumer ready; transfer when SRC_RDY and DST_RDY are both high.

## Operation
- Per channel: registers DISC_CNT, PASS_CNT (CNT_W) and OVF (1). Each cycle nd = popcount(VLD & DISC), np = popcount(VLD & ~DISC) over that channel's REGIONS bits.
- Counter update: next = base + n, saturating at 2^CNT_W-1. Saturation, whether the sum exceeds max or the counter is already at max with n>0, sets OVF.
- base = 0 and OVF cleared first when the channel is loaded into the output register this cycle. Otherwise base = current value. Events arriving in the load cycle are never lost; they seed the cleared counters.
- Pending(ch) = DISC_CNT != 0 or PASS_CNT != 0.
- Output register (TX_*) is free when TX_SRC_RDY = 0, or when a transfer happens this cycle.
- When free and any channel is pending:
  - Grant the first pending channel at or after PTR, ascending with wrap.
  - Load TX_CHAN/TX_DISC_CNT/TX_PASS_CNT/TX_OVF from that channel's registers and set TX_SRC_RDY = 1.
  - Set PTR = grant+1, wrapping ETH_CHANNELS-1 -> 0.
- When free and nothing is pending: TX_SRC_RDY = 0. Other TX_* hold their last value; they are don't-care.
- While TX_SRC_RDY = 1 and TX_DST_RDY = 0, all TX_* outputs hold stable. No channel is cleared; counters keep accumulating.
- At most one grant per cycle. Back-to-back records are possible with DST_RDY held high.
- ETH_CHANNELS = 1: PTR is constant 0 and TX_CHAN is constant 0.

## Timing
- Reset (async assert, sync deassert handled upstream) clears all of:
  - every counter and OVF;
  - PTR = 0;
  - TX_SRC_RDY = 0, TX_CHAN = 0, TX_DISC_CNT = 0, TX_PASS_CNT = 0, TX_OVF = 0.
- Reset mid-record: the pending record and all counts are dropped, with no partial output.
- Latency: an event sampled at edge t is in a counter after t. If the output is free in cycle t+1, the record is loaded at edge t+1, so TX_SRC_RDY = 1 in cycle t+2. Minimum event-to-record latency is 2 cycles.
- Throughput: one record per cycle. Each channel waits at most ETH_CHANNELS grants while pending.
- Simultaneous events:
  - events on the granted channel in the load cycle go to that channel's new counter, not to the loaded record;
  - events on other channels accumulate normally.
- Sum of all record counts equals the sum of input events, except where TX_OVF = 1.

## Test plan
- Single event: ch2 discard at cycle 10, DST_RDY = 1 -> record chan=2, disc=1, pass=0, ovf=0 with SRC_RDY at cycle 12 only.
- Fairness: ETH_CHANNELS = 4, all channels fire one pass event every cycle, DST_RDY = 1 -> TX_CHAN sequence 0,1,2,3,0,… Each record after the first per channel has pass=4.
- Backpressure: ch1 gets 3 discards, DST_RDY = 0 for 20 cycles while ch1 gets 5 more passes -> outputs stable during stall. Then record (1,3,0), then next record (1,0,5).
- Load-cycle collision: REGIONS = 2, ch0 gets 2 events in the same cycle its record is loaded -> that record excludes them; the following ch0 record carries exactly 2.
- Saturation: CNT_W = 4, 20 discards on ch3 with DST_RDY = 0 -> record disc=15, ovf=1. The next record has ovf=0.
- Reset: RESET asserted asynchronously while SRC_RDY = 1 and counters are nonzero -> all outputs 0 immediately. After release with no events, SRC_RDY stays 0.

Source files
------------

// File: rtl/rx_event_scheduler.sv
// rx_event_scheduler: collects per-channel RX MAC Lite frame outcomes
// (passed/discarded) into saturating pending counters and serialises them
// round-robin into a single MVB record stream.
//
// Ports:
//   CLK          clock, rising edge
//   RESET        asynchronous active-high reset
//   RX_EV_VLD    per channel/region event valid (bit ch*REGIONS+r)
//   RX_EV_DISC   1 = discarded, 0 = passed (qualified by RX_EV_VLD)
//   TX_CHAN      channel ID of the record
//   TX_DISC_CNT  discarded frames in the record
//   TX_PASS_CNT  passed frames in the record
//   TX_OVF       a counter of this record saturated
//   TX_SRC_RDY   record valid
//   TX_DST_RDY   consumer ready
module rx_event_scheduler #(
  parameter int unsigned ETH_CHANNELS = 4,
  parameter int unsigned REGIONS      = 1,
  parameter int unsigned CNT_W        = 16,
  localparam int unsigned CH_W = (ETH_CHANNELS > 1) ? $clog2(ETH_CHANNELS) : 1
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic [ETH_CHANNELS*REGIONS-1:0] RX_EV_VLD,
  input  logic [ETH_CHANNELS*REGIONS-1:0] RX_EV_DISC,
  output logic [CH_W-1:0]                 TX_CHAN,
  output logic [CNT_W-1:0]                TX_DISC_CNT,
  output logic [CNT_W-1:0]                TX_PASS_CNT,
  output logic                            TX_OVF,
  output logic                            TX_SRC_RDY,
  input  logic                            TX_DST_RDY
);

  localparam int unsigned NW    = $clog2(REGIONS + 1);
  localparam int unsigned SUM_W = CNT_W + NW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] disc_q [ETH_CHANNELS];
  logic [CNT_W-1:0] disc_d [ETH_CHANNELS];
  logic [CNT_W-1:0] pass_q [ETH_CHANNELS];
  logic [CNT_W-1:0] pass_d [ETH_CHANNELS];
  logic [ETH_CHANNELS-1:0] ovf_q, ovf_d;
  logic [ETH_CHANNELS-1:0] pending;
  logic [CH_W-1:0]  ptr_q, ptr_d;

  logic [CH_W-1:0]  tx_chan_q, tx_chan_d;
  logic [CNT_W-1:0] tx_disc_q, tx_disc_d;
  logic [CNT_W-1:0] tx_pass_q, tx_pass_d;
  logic             tx_ovf_q, tx_ovf_d;
  logic             tx_src_rdy_q, tx_src_rdy_d;

  logic             tx_free, found, load, clr, sat_d, sat_p;
  logic [CH_W-1:0]  grant;
  logic [CH_W:0]    cand;
  logic [NW-1:0]    nd, np;
  logic [CNT_W-1:0] base_disc, base_pass;
  logic [SUM_W-1:0] sum_disc, sum_pass;

  // Arbitration, output register and counter next-state
  always_comb begin
    tx_free      = !tx_src_rdy_q || TX_DST_RDY;
    found        = 1'b0;
    grant        = '0;
    cand         = '0;
    ptr_d        = ptr_q;
    tx_chan_d    = tx_chan_q;
    tx_disc_d    = tx_disc_q;
    tx_pass_d    = tx_pass_q;
    tx_ovf_d     = tx_ovf_q;
    tx_src_rdy_d = tx_src_rdy_q;
    clr          = 1'b0;
    sat_d        = 1'b0;
    sat_p        = 1'b0;
    nd           = '0;
    np           = '0;
    base_disc    = '0;
    base_pass    = '0;
    sum_disc     = '0;
    sum_pass     = '0;
    ovf_d        = ovf_q;

    for (int unsigned ch = 0; ch < ETH_CHANNELS; ch++) begin
      pending[ch] = (disc_q[ch] != '0) || (pass_q[ch] != '0);
    end

    // First pending channel at or after ptr, wrapping
    for (int unsigned i = 0; i < ETH_CHANNELS; i++) begin
      cand = {1'b0, ptr_q} + (CH_W+1)'(i);
      if (cand >= (CH_W+1)'(ETH_CHANNELS)) begin
        cand = cand - (CH_W+1)'(ETH_CHANNELS);
      end
      if (!found && pending[CH_W'(cand)]) begin
        found = 1'b1;
        grant = CH_W'(cand);
      end
    end

    load = tx_free && found;

    if (tx_free) begin
      tx_src_rdy_d = found;
      if (found) begin
        tx_chan_d = grant;
        tx_disc_d = disc_q[grant];
        tx_pass_d = pass_q[grant];
        tx_ovf_d  = ovf_q[grant];
        ptr_d     = (grant == CH_W'(ETH_CHANNELS - 1)) ? '0 : grant + CH_W'(1);
      end
    end

    // The loaded channel restarts from zero; same-cycle events seed it
    for (int unsigned ch = 0; ch < ETH_CHANNELS; ch++) begin
      nd = '0;
      np = '0;
      for (int unsigned r = 0; r < REGIONS; r++) begin
        if (RX_EV_VLD[ch*REGIONS+r]) begin
          if (RX_EV_DISC[ch*REGIONS+r]) nd = nd + NW'(1);
          else                          np = np + NW'(1);
        end
      end
      clr       = load && (grant == CH_W'(ch));
      base_disc = clr ? '0 : disc_q[ch];
      base_pass = clr ? '0 : pass_q[ch];
      sum_disc  = SUM_W'(base_disc) + SUM_W'(nd);
      sum_pass  = SUM_W'(base_pass) + SUM_W'(np);
      sat_d     = sum_disc > SUM_W'(CNT_MAX);
      sat_p     = sum_pass > SUM_W'(CNT_MAX);
      disc_d[ch] = sat_d ? CNT_MAX : CNT_W'(sum_disc);
      pass_d[ch] = sat_p ? CNT_MAX : CNT_W'(sum_pass);
      ovf_d[ch]  = (!clr && ovf_q[ch]) || sat_d || sat_p;
    end
  end

  // State registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned ch = 0; ch < ETH_CHANNELS; ch++) begin
        disc_q[ch] <= '0;
        pass_q[ch] <= '0;
      end
      ovf_q        <= '0;
      ptr_q        <= '0;
      tx_chan_q    <= '0;
      tx_disc_q    <= '0;
      tx_pass_q    <= '0;
      tx_ovf_q     <= 1'b0;
      tx_src_rdy_q <= 1'b0;
    end else begin
      for (int unsigned ch = 0; ch < ETH_CHANNELS; ch++) begin
        disc_q[ch] <= disc_d[ch];
        pass_q[ch] <= pass_d[ch];
      end
      ovf_q        <= ovf_d;
      ptr_q        <= ptr_d;
      tx_chan_q    <= tx_chan_d;
      tx_disc_q    <= tx_disc_d;
      tx_pass_q    <= tx_pass_d;
      tx_ovf_q     <= tx_ovf_d;
      tx_src_rdy_q <= tx_src_rdy_d;
    end
  end

  assign TX_CHAN     = tx_chan_q;
  assign TX_DISC_CNT = tx_disc_q;
  assign TX_PASS_CNT = tx_pass_q;
  assign TX_OVF      = tx_ovf_q;
  assign TX_SRC_RDY  = tx_src_rdy_q;

endmodule

// File: tb/tb_rx_event_scheduler.sv
// Directed bench for rx_event_scheduler: 4 channels, 2 regions, 4-bit counters.
// Observed record is packed as {SRC_RDY, CHAN[1:0], DISC[3:0], PASS[3:0], OVF}.
module tb_rx_event_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned R  = 2;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*R-1:0] vld, disc;
  logic          dst;
  logic [1:0]    tx_chan;
  logic [CW-1:0] tx_disc, tx_pass;
  logic          tx_ovf, tx_src_rdy;
  logic [11:0]   obs;
  logic [11:0]   exp_rec;

  int checks = 0;
  int errors = 0;

  rx_event_scheduler #(
    .ETH_CHANNELS(N),
    .REGIONS     (R),
    .CNT_W       (CW)
  ) dut (
    .CLK        (clk),
    .RESET      (rst),
    .RX_EV_VLD  (vld),
    .RX_EV_DISC (disc),
    .TX_CHAN    (tx_chan),
    .TX_DISC_CNT(tx_disc),
    .TX_PASS_CNT(tx_pass),
    .TX_OVF     (tx_ovf),
    .TX_SRC_RDY (tx_src_rdy),
    .TX_DST_RDY (dst)
  );

  always #5 clk = ~clk;

  assign obs = {tx_src_rdy, tx_chan, tx_disc, tx_pass, tx_ovf};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    vld = '0;
    disc = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = '0; disc = '0; dst = 1'b0;
    step();
    step();
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs, 12'h000);
    end
    rst = 1'b0;
    step();
    checks++;
    if (tx_src_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: src_rdy got %b expected 0", tx_src_rdy);
    end
  endtask

  task automatic test_single_event();
    do_reset();
    dst = 1'b1;
    repeat (5) step();
    vld = 8'h10; disc = 8'h10;
    step();
    vld = '0; disc = '0;
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("FAIL single_t1: got %h expected %h", obs, 12'h000);
    end
    step();
    exp_rec = {1'b1, 2'd2, 4'd1, 4'd0, 1'b0};
    checks++;
    if (obs !== exp_rec) begin
      errors++;
      $display("FAIL single_t2: got %h expected %h", obs, exp_rec);
    end
    step();
    checks++;
    if (tx_src_rdy !== 1'b0) begin
      errors++;
      $display("FAIL single_t3: src_rdy got %b expected 0", tx_src_rdy);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    dst = 1'b1;
    vld = 8'h55; disc = '0;
    step();
    checks++;
    if (tx_src_rdy !== 1'b0) begin
      errors++;
      $display("FAIL fair_first: src_rdy got %b expected 0", tx_src_rdy);
    end
    for (int k = 0; k < 12; k++) begin
      step();
      exp_rec = {1'b1, 2'(k % 4), 4'd0, 4'((k < 4) ? k + 1 : 4), 1'b0};
      checks++;
      if (obs !== exp_rec) begin
        errors++;
        $display("FAIL fair_rec%0d: got %h expected %h", k, obs, exp_rec);
      end
    end
    vld = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    dst = 1'b0;
    vld = 8'h01; disc = 8'h00;
    step();
    vld = 8'h0C; disc = 8'h0C;
    step();
    vld = 8'h04; disc = 8'h04;
    step();
    vld = '0; disc = '0;
    exp_rec = {1'b1, 2'd0, 4'd0, 4'd1, 1'b0};
    checks++;
    if (obs !== exp_rec) begin
      errors++;
      $display("FAIL bp_block: got %h expected %h", obs, exp_rec);
    end
    dst = 1'b1;
    step();
    dst = 1'b0;
    exp_rec = {1'b1, 2'd1, 4'd3, 4'd0, 1'b0};
    checks++;
    if (obs !== exp_rec) begin
      errors++;
      $display("FAIL bp_rec1: got %h expected %h", obs, exp_rec);
    end
    for (int c = 0; c < 20; c++) begin
      vld  = (c < 2) ? 8'h0C : ((c == 2) ? 8'h04 : 8'h00);
      disc = '0;
      step();
      checks++;
      if (obs !== exp_rec) begin
        errors++;
        $display("FAIL bp_stall%0d: got %h expected %h", c, obs, exp_rec);
      end
    end
    vld = '0;
    dst = 1'b1;
    step();
    exp_rec = {1'b1, 2'd1, 4'd0, 4'd5, 1'b0};
    checks++;
    if (obs !== exp_rec) begin
      errors++;
      $display("FAIL bp_rec2: got %h expected %h", obs, exp_rec);
    end
    step();
    checks++;
    if (tx_src_rdy !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: src_rdy got %b expected 0", tx_src_rdy);
    end
  endtask

  task automatic test_collision();
    do_reset();
    dst = 1'b1;
    vld = 8'h01; disc = 8'h00;
    step();
    vld = 8'h03; disc = 8'h02;
    step();
    vld = '0; disc = '0;
    exp_rec = {1'b1, 2'd0, 4'd0, 4'd1, 1'b0};
    checks++;
    if (obs !== exp_rec) begin
      errors++;
      $display("FAIL coll_rec1: got %h expected %h", obs, exp_rec);
    end
    step();
    exp_rec = {1'b1, 2'd0, 4'd1, 4'd1, 1'b0};
    checks++;
    if (obs !== exp_rec) begin
      errors++;
      $display("FAIL coll_rec2: got %h expected %h", obs, exp_rec);
    end
    step();
    checks++;
    if (tx_src_rdy !== 1'b0) begin
      errors++;
      $display("FAIL coll_drain: src_rdy got %b expected 0", tx_src_rdy);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    dst = 1'b0;
    vld = 8'h01; disc = 8'h00;
    step();
    vld = 8'hC0; disc = 8'hC0;
    repeat (10) step();
    vld = '0; disc = '0;
    exp_rec = {1'b1, 2'd0, 4'd0, 4'd1, 1'b0};
    checks++;
    if (obs !== exp_rec) begin
      errors++;
      $display("FAIL sat_block: got %h expected %h", obs, exp_rec);
    end
    dst = 1'b1;
    step();
    exp_rec = {1'b1, 2'd3, 4'd15, 4'd0, 1'b1};
    checks++;
    if (obs !== exp_rec) begin
      errors++;
      $display("FAIL sat_rec: got %h expected %h", obs, exp_rec);
    end
    step();
    checks++;
    if (tx_src_rdy !== 1'b0) begin
      errors++;
      $display("FAIL sat_drain: src_rdy got %b expected 0", tx_src_rdy);
    end
    vld = 8'h40; disc = 8'h40;
    step();
    vld = '0; disc = '0;
    step();
    exp_rec = {1'b1, 2'd3, 4'd1, 4'd0, 1'b0};
    checks++;
    if (obs !== exp_rec) begin
      errors++;
      $display("FAIL sat_next: got %h expected %h", obs, exp_rec);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    dst = 1'b0;
    vld = 8'h10; disc = 8'h10;
    step();
    vld = 8'h04; disc = 8'h00;
    step();
    vld = '0; disc = '0;
    exp_rec = {1'b1, 2'd2, 4'd1, 4'd0, 1'b0};
    checks++;
    if (obs !== exp_rec) begin
      errors++;
      $display("FAIL rmid_pre: got %h expected %h", obs, exp_rec);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("FAIL rmid_async: got %h expected %h", obs, 12'h000);
    end
    step();
    rst = 1'b0;
    dst = 1'b1;
    repeat (4) step();
    checks++;
    if (tx_src_rdy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_after: src_rdy got %b expected 0", tx_src_rdy);
    end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_fairness();
    test_backpressure();
    test_collision();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
